// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB and 2-bit direction counters.
// Execute-stage resolutions train the BTB; mispredicts redirect fetch.
module pc_predict_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  UpdateE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic                  TakenE,
  input  logic [DATA_WIDTH-1:0] TargetE,
  input  logic                  MispredictE,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  PredTakenF,
  output logic [DATA_WIDTH-1:0] PredTargetF,
  output logic [CNT_WIDTH-1:0]  MispredCount
);

  localparam int IDX_BITS = $clog2(BTB_ENTRIES);
  localparam int TAG_W    = DATA_WIDTH - IDX_BITS - 2;
  localparam int TGT_W    = DATA_WIDTH - 2;

  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [TGT_W-1:0] tgt_q   [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];

  logic [IDX_BITS-1:0] idx_f;
  logic [IDX_BITS-1:0] idx_e;
  logic [TAG_W-1:0]    tag_f;
  logic [TAG_W-1:0]    tag_e;
  logic                hit_f;
  logic                hit_e;
  logic                redirect;
  logic [DATA_WIDTH-1:0] redir_pc;
  logic                unused_tgt;

  assign unused_tgt = ^TargetE[1:0];

  assign idx_f = PCF[IDX_BITS+1:2];
  assign tag_f = PCF[DATA_WIDTH-1:IDX_BITS+2];
  assign idx_e = PCE[IDX_BITS+1:2];
  assign tag_e = PCE[DATA_WIDTH-1:IDX_BITS+2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign PCPlus4F    = PCF + DATA_WIDTH'(4);
  assign PredTakenF  = hit_f && ctr_q[idx_f][1];
  assign PredTargetF = PredTakenF ? {tgt_q[idx_f], 2'b00}
                                  : PCPlus4F;

  assign redirect = UpdateE && MispredictE;
  assign redir_pc = TakenE ? {TargetE[DATA_WIDTH-1:2], 2'b00}
                           : PCE + DATA_WIDTH'(4);

  // Redirect beats stall so the recovery path is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCF <= RESET_VECTOR;
    end else if (redirect) begin
      PCF <= redir_pc;
    end else if (enable) begin
      PCF <= PredTargetF;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MispredCount <= '0;
    end else if (redirect && (MispredCount != '1)) begin
      MispredCount <= MispredCount + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (UpdateE) begin
      if (hit_e) begin
        if (TakenE) begin
          if (ctr_q[idx_e] != 2'b11)
            ctr_q[idx_e] <= ctr_q[idx_e] + 2'd1;
          tgt_q[idx_e] <= TargetE[DATA_WIDTH-1:2];
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_q[idx_e] <= ctr_q[idx_e] - 2'd1;
        end
      end else if (TakenE) begin
        // New taken branch starts weakly taken.
        valid_q[idx_e] <= 1'b1;
        tag_q[idx_e]   <= tag_e;
        tgt_q[idx_e]   <= TargetE[DATA_WIDTH-1:2];
        ctr_q[idx_e]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit with an expectation queue.
// Narrow mispredict counter so saturation is reachable.
module tb_pc_predict_unit;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        UpdateE;
  logic [31:0] PCE;
  logic        TakenE;
  logic [31:0] TargetE;
  logic        MispredictE;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic [1:0]  MispredCount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    logic [31:0] v;
    string       n;
  } exp_t;

  exp_t q[$];

  pc_predict_unit #(
    .DATA_WIDTH(32),
    .RESET_VECTOR(32'hBFC00000),
    .BTB_ENTRIES(16),
    .CNT_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .UpdateE(UpdateE),
    .PCE(PCE),
    .TakenE(TakenE),
    .TargetE(TargetE),
    .MispredictE(MispredictE),
    .PCF(PCF),
    .PCPlus4F(PCPlus4F),
    .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF),
    .MispredCount(MispredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int k);
    case (k)
      0: return PCF;
      1: return {31'b0, PredTakenF};
      2: return PredTargetF;
      3: return {30'b0, MispredCount};
      default: return PCPlus4F;
    endcase
  endfunction

  task automatic ex(string n, int k, logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.v = v;
    e.n = n;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.kind);
      checks++;
      assert (o === e.v) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.n, o, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(logic [31:0] pc, logic tk,
                     logic [31:0] tg, logic mp);
    UpdateE = 1'b1;
    PCE = pc;
    TakenE = tk;
    TargetE = tg;
    MispredictE = mp;
  endtask

  task automatic idle();
    UpdateE = 1'b0;
    MispredictE = 1'b0;
    TakenE = 1'b0;
    PCE = '0;
    TargetE = '0;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    idle();
    tick();
    tick();
    ex("rst_pcf", 0, 32'hBFC00000);
    ex("rst_pt", 1, 0);
    ex("rst_ptgt", 2, 32'hBFC00004);
    ex("rst_cnt", 3, 0);
    drain();

    reset = 1'b1;
    tick();
    ex("seq1", 0, 32'hBFC00004);
    drain();
    tick();
    ex("seq2", 0, 32'hBFC00008);
    ex("seq2_pt", 1, 0);
    drain();
    tick();

    #2 reset = 1'b0;
    #1;
    ex("async_rst", 0, 32'hBFC00000);
    ex("async_cnt", 3, 0);
    drain();
    reset = 1'b1;
    tick();
    ex("rel1", 0, 32'hBFC00004);
    drain();
    tick();
    tick();
    tick();
    ex("seq4", 0, 32'hBFC00010);
    ex("seq4_pt", 1, 0);
    drain();

    upd(32'hBFC00010, 1'b1, 32'hBFC00100, 1'b1);
    ex("alloc_pre_pt", 1, 0);
    drain();
    tick();
    idle();
    ex("alloc_pcf", 0, 32'hBFC00100);
    ex("alloc_cnt", 3, 1);
    drain();

    enable = 1'b0;
    upd(32'hBFC0000C, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    ex("nt_redir_pcf", 0, 32'hBFC00010);
    ex("nt_redir_cnt", 3, 2);
    ex("pred_pt", 1, 1);
    ex("pred_tgt", 2, 32'hBFC00100);
    drain();
    tick();
    ex("stall_hold", 0, 32'hBFC00010);
    drain();

    upd(32'hBFC00010, 1'b0, 32'h0, 1'b0);
    ex("same_idx_pre", 1, 1);
    drain();
    tick();
    idle();
    ex("hyst_nt_pt", 1, 0);
    ex("hyst_nt_tgt", 2, 32'hBFC00014);
    ex("hyst_hold", 0, 32'hBFC00010);
    drain();

    upd(32'hBFC00010, 1'b1, 32'hBFC00100, 1'b0);
    tick();
    ex("hyst_t1_pt", 1, 1);
    drain();
    tick();
    tick();
    tick();
    upd(32'hBFC00010, 1'b1, 32'hBFC00303, 1'b0);
    tick();
    upd(32'hBFC00010, 1'b0, 32'h0, 1'b0);
    tick();
    ex("sat_nt1_pt", 1, 1);
    ex("sat_nt1_tgt", 2, 32'hBFC00300);
    drain();
    tick();
    idle();
    ex("sat_nt2_pt", 1, 0);
    ex("sat_nt2_tgt", 2, 32'hBFC00014);
    drain();

    upd(32'hBFC00050, 1'b1, 32'hBFC00500, 1'b0);
    tick();
    idle();
    ex("alias_miss_pt", 1, 0);
    ex("alias_miss_tgt", 2, 32'hBFC00014);
    drain();
    upd(32'hBFC0004C, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    ex("alias_pcf", 0, 32'hBFC00050);
    ex("alias_pt", 1, 1);
    ex("alias_tgt", 2, 32'hBFC00500);
    ex("alias_cnt", 3, 3);
    drain();
    upd(32'hBFC00010, 1'b1, 32'hBFC00100, 1'b0);
    tick();
    idle();
    ex("alias_back_pt", 1, 0);
    ex("alias_back_tgt", 2, 32'hBFC00054);
    drain();

    upd(32'hBFC00020, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    ex("stall_redir", 0, 32'hBFC00024);
    ex("cnt_sat4", 3, 3);
    drain();
    tick();
    ex("stall_after", 0, 32'hBFC00024);
    drain();

    upd(32'hBFC00024, 1'b1, 32'h00001003, 1'b1);
    tick();
    idle();
    ex("jalr_align", 0, 32'h00001000);
    ex("cnt_sat5", 3, 3);
    drain();

    MispredictE = 1'b1;
    TakenE = 1'b1;
    TargetE = 32'h00002000;
    tick();
    idle();
    ex("misp_no_upd", 0, 32'h00001000);
    drain();

    upd(32'h00000F00, 1'b1, 32'hFFFFFFFC, 1'b1);
    tick();
    idle();
    ex("wrap_pcf", 0, 32'hFFFFFFFC);
    ex("wrap_plus4", 4, 32'h0);
    ex("wrap_pt", 1, 0);
    ex("wrap_ptgt", 2, 32'h0);
    drain();
    enable = 1'b1;
    tick();
    ex("wrap_next", 0, 32'h0);
    ex("zero_pt", 1, 0);
    ex("zero_ptgt", 2, 32'h4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
